// File: rtl/sbox_share_sched.sv
// sbox_share_sched
// ----------------
// Shares one external 4-lane (32-bit) combinational S-box bank between the
// round datapath (SubBytes over a 128-bit state, four beats) and key
// expansion (SubWord over one 32-bit word, one beat).
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   st_req/st_in        state job request (level) and 128-bit state
//   st_ack              pulses in the cycle the state job is accepted
//   st_done/st_out      st_done pulses when st_out is valid; st_out held
//   key_req/key_in      key job request (level) and 32-bit word
//   key_ack             pulses in the cycle the key job is accepted
//   key_done/key_out    key_done pulses when key_out is valid; key_out held
//   sb_in/sb_out        to / from the shared S-box lanes (31:24 = lane 0)
//   busy                high whenever the scheduler is not IDLE
//
// Parameters
//   KEY_PRIO  tie-break from IDLE: 1 grants key, 0 grants state
//   ST_BEATS  beats per state job, must be 4
//
// Optional build macro: SBOX_SHARE_KEY_INTERLEAVE_EN
//   When defined, a pending key job may be slotted into the middle of a
//   state job (once per state job); the key word then lives in its own
//   register so the state work register is left intact.
module sbox_share_sched #(
    parameter int KEY_PRIO = 1,
    parameter int ST_BEATS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_req,
    input  logic [127:0] st_in,
    output logic         st_ack,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         key_req,
    input  logic [31:0]  key_in,
    output logic         key_ack,
    output logic         key_done,
    output logic [31:0]  key_out,
    output logic [31:0]  sb_in,
    input  logic [31:0]  sb_out,
    output logic         busy
);

    generate
        if (ST_BEATS != 4) begin : g_bad_beats
            $error("sbox_share_sched: ST_BEATS must be 4");
        end
    endgenerate

    localparam logic [1:0] LAST_BEAT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ST_BEAT,
        KEY_BEAT,
        DONE_ST,
        DONE_KEY
    } state_t;

    state_t       state_reg, state_next;
    logic [1:0]   cnt_reg, cnt_next;
    logic [127:0] work_reg;
    logic [95:0]  res_reg;        // words 0..2 of the state result in flight
    logic [127:0] st_out_reg;
    logic [31:0]  key_out_reg;
    logic [31:0]  work_words [4];
    logic [31:0]  key_word;
    logic         arb_en;
    logic         prefer_key;
    logic         grant_st;
    logic         grant_key;

    // Word 0 is the most significant word of the state.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_words
            assign work_words[gi] = work_reg[127 - 32*gi -: 32];
        end
    endgenerate

`ifdef SBOX_SHARE_KEY_INTERLEAVE_EN
    logic [31:0] key_work_reg;
    logic        il_used_reg;     // this state job already hosted a key job
    logic        il_active_reg;   // current key job was slotted mid-state
    assign key_word = key_work_reg;
`else
    assign key_word = work_reg[31:0];
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        arb_en     = 1'b0;
        prefer_key = (KEY_PRIO != 0);
        grant_st   = 1'b0;
        grant_key  = 1'b0;
        sb_in      = 32'd0;

        case (state_reg)
            IDLE: begin
                arb_en = 1'b1;
            end
            ST_BEAT: begin
                sb_in    = work_words[cnt_reg];
                cnt_next = cnt_reg + 2'd1;
                if (cnt_reg == LAST_BEAT) begin
                    state_next = DONE_ST;
                end
`ifdef SBOX_SHARE_KEY_INTERLEAVE_EN
                else if (key_req && !il_used_reg) begin
                    // cnt still advances, so the resume point is saved in cnt_reg
                    grant_key  = 1'b1;
                    state_next = KEY_BEAT;
                end
`endif
            end
            KEY_BEAT: begin
                sb_in      = key_word;
                state_next = DONE_KEY;
            end
            DONE_ST: begin
                // Just-served state loses a tie so key cannot starve.
                state_next = IDLE;
                arb_en     = 1'b1;
                prefer_key = 1'b1;
            end
            DONE_KEY: begin
                state_next = IDLE;
                arb_en     = 1'b1;
                prefer_key = 1'b0;
`ifdef SBOX_SHARE_KEY_INTERLEAVE_EN
                if (il_active_reg) begin
                    state_next = ST_BEAT;
                    arb_en     = 1'b0;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (arb_en) begin
            if (st_req && key_req) begin
                grant_key = prefer_key;
                grant_st  = !prefer_key;
            end else begin
                grant_key = key_req;
                grant_st  = st_req;
            end
        end

        if (grant_st) begin
            state_next = ST_BEAT;
            cnt_next   = 2'd0;
        end else if (grant_key) begin
            state_next = KEY_BEAT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 2'd0;
            work_reg    <= 128'd0;
            res_reg     <= 96'd0;
            st_out_reg  <= 128'd0;
            key_out_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (grant_st) begin
                work_reg <= st_in;
            end
`ifndef SBOX_SHARE_KEY_INTERLEAVE_EN
            if (grant_key) begin
                work_reg[31:0] <= key_in;
            end
`endif
            if (state_reg == ST_BEAT) begin
                case (cnt_reg)
                    2'd0:    res_reg[95:64] <= sb_out;
                    2'd1:    res_reg[63:32] <= sb_out;
                    2'd2:    res_reg[31:0]  <= sb_out;
                    default: st_out_reg     <= {res_reg, sb_out};
                endcase
            end
            if (state_reg == KEY_BEAT) begin
                key_out_reg <= sb_out;
            end
        end
    end

`ifdef SBOX_SHARE_KEY_INTERLEAVE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            key_work_reg  <= 32'd0;
            il_used_reg   <= 1'b0;
            il_active_reg <= 1'b0;
        end else begin
            if (grant_key) begin
                key_work_reg <= key_in;
            end
            if (grant_st) begin
                il_used_reg <= 1'b0;
            end else if (grant_key && state_reg == ST_BEAT) begin
                il_used_reg   <= 1'b1;
                il_active_reg <= 1'b1;
            end
            if (state_reg == DONE_KEY) begin
                il_active_reg <= 1'b0;
            end
        end
    end
`endif

    // Acks come straight from arbitration; masked while reset is applied.
    assign st_ack   = grant_st & ~rst;
    assign key_ack  = grant_key & ~rst;
    assign st_done  = (state_reg == DONE_ST);
    assign key_done = (state_reg == DONE_KEY);
    assign st_out   = st_out_reg;
    assign key_out  = key_out_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_sbox_share_sched.sv
module tb_sbox_share_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         st_req = 1'b0, key_req = 1'b0;
    logic [127:0] st_in = '0;
    logic [31:0]  key_in = '0;
    logic         st_ack, st_done, key_ack, key_done, busy;
    logic [127:0] st_out;
    logic [31:0]  key_out, sb_in, sb_out;

    // second instance with KEY_PRIO = 0, shares rst/st_in/key_in
    logic         st_req_p0 = 1'b0, key_req_p0 = 1'b0;
    logic         st_ack_p0, st_done_p0, key_ack_p0, key_done_p0, busy_p0;
    logic [127:0] st_out_p0;
    logic [31:0]  key_out_p0, sb_in_p0, sb_out_p0;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]    sbox [256];
    logic [0:2047] sbox_flat;

    always #5 clk = ~clk;

    sbox_share_sched #(.KEY_PRIO(1), .ST_BEATS(4)) dut (
        .clk(clk), .rst(rst),
        .st_req(st_req), .st_in(st_in), .st_ack(st_ack), .st_done(st_done), .st_out(st_out),
        .key_req(key_req), .key_in(key_in), .key_ack(key_ack), .key_done(key_done), .key_out(key_out),
        .sb_in(sb_in), .sb_out(sb_out), .busy(busy)
    );

    sbox_share_sched #(.KEY_PRIO(0), .ST_BEATS(4)) dut_p0 (
        .clk(clk), .rst(rst),
        .st_req(st_req_p0), .st_in(st_in), .st_ack(st_ack_p0), .st_done(st_done_p0), .st_out(st_out_p0),
        .key_req(key_req_p0), .key_in(key_in), .key_ack(key_ack_p0), .key_done(key_done_p0), .key_out(key_out_p0),
        .sb_in(sb_in_p0), .sb_out(sb_out_p0), .busy(busy_p0)
    );

    // FIPS-197 S-box lanes
    assign sb_out    = {sbox[sb_in[31:24]], sbox[sb_in[23:16]], sbox[sb_in[15:8]], sbox[sb_in[7:0]]};
    assign sb_out_p0 = {sbox[sb_in_p0[31:24]], sbox[sb_in_p0[23:16]], sbox[sb_in_p0[15:8]], sbox[sb_in_p0[7:0]]};

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        #1;
        n_cmp++; if ({st_ack, st_done, key_ack, key_done, busy} !== 5'b0) begin n_err++;
            $display("FAIL reset_flags: got %b want 00000", {st_ack, st_done, key_ack, key_done, busy}); end
        n_cmp++; if (st_out !== 128'd0) begin n_err++; $display("FAIL reset_st_out: got %h want 0", st_out); end
        n_cmp++; if (key_out !== 32'd0) begin n_err++; $display("FAIL reset_key_out: got %h want 0", key_out); end
        n_cmp++; if (sb_in !== 32'd0) begin n_err++; $display("FAIL reset_sb_in: got %h want 0", sb_in); end
        n_cmp++; if ((|{st_ack_p0, st_done_p0, key_ack_p0, key_done_p0, busy_p0, st_out_p0, key_out_p0, sb_in_p0}) !== 1'b0) begin
            n_err++; $display("FAIL reset_p0_outputs: got nonzero want all 0"); end
        st_req = 1'b1;
        #1;
        n_cmp++; if (st_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack_masked: got %b want 0", st_ack); end
        st_req = 1'b0;
        rst = 1'b0;
        step();
        $display("reset: done");
    endtask

    task automatic test_state_job();
        logic [127:0] vin;
        vin = 128'h00112233_44556677_8899aabb_ccddeeff;
        st_in = vin; st_req = 1'b1;
        #1;
        n_cmp++; if ({st_ack, busy} !== 2'b10) begin n_err++; $display("FAIL state_ack: got ack/busy %b want 10", {st_ack, busy}); end
        step();
        st_req = 1'b0; st_in = '1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (sb_in !== vin[127 - 32*k -: 32]) begin n_err++;
                $display("FAIL state_beat%0d_sb_in: got %h want %h", k, sb_in, vin[127 - 32*k -: 32]); end
            n_cmp++; if ({st_done, busy} !== 2'b01) begin n_err++;
                $display("FAIL state_beat%0d_flags: got done/busy %b want 01", k, {st_done, busy}); end
            step();
        end
        #1;
        n_cmp++; if (st_done !== 1'b1) begin n_err++; $display("FAIL state_done_T5: got %b want 1", st_done); end
        n_cmp++; if (st_out !== 128'h638293c3_1bfc33f5_c4eeacea_4bc12816) begin n_err++;
            $display("FAIL state_out: got %h want 638293c31bfc33f5c4eeacea4bc12816", st_out); end
        $display("state job: in=%h out=%h", vin, st_out);
        step(); #1;
        n_cmp++; if ({st_done, busy, st_out} !== {2'b00, 128'h638293c3_1bfc33f5_c4eeacea_4bc12816}) begin n_err++;
            $display("FAIL state_hold: got done/busy %b out %h", {st_done, busy}, st_out); end
    endtask

    task automatic test_key_only();
        step();
        key_in = 32'h09cf4f3c; key_req = 1'b1;
        #1;
        n_cmp++; if ({key_ack, st_ack} !== 2'b10) begin n_err++; $display("FAIL key_ack: got key/st %b want 10", {key_ack, st_ack}); end
        step();
        key_req = 1'b0; key_in = 32'd0;
        #1;
        n_cmp++; if (sb_in !== 32'h09cf4f3c) begin n_err++; $display("FAIL key_sb_in: got %h want 09cf4f3c", sb_in); end
        n_cmp++; if (key_done !== 1'b0) begin n_err++; $display("FAIL key_done_early: got %b want 0", key_done); end
        step(); #1;
        n_cmp++; if (key_done !== 1'b1) begin n_err++; $display("FAIL key_done_T2: got %b want 1", key_done); end
        n_cmp++; if (key_out !== 32'h018a84eb) begin n_err++; $display("FAIL key_out: got %h want 018a84eb", key_out); end
        n_cmp++; if (st_out !== 128'h638293c3_1bfc33f5_c4eeacea_4bc12816) begin n_err++;
            $display("FAIL key_st_out_held: got %h", st_out); end
        $display("key job: in=09cf4f3c out=%h", key_out);
        step(); #1;
        n_cmp++; if ({key_done, busy} !== 2'b00) begin n_err++; $display("FAIL key_idle: got done/busy %b want 00", {key_done, busy}); end
    endtask

    task automatic test_simultaneous();
        int sa = -1, ka = -1, sd = -1, kd = -1;
        int sa0 = -1, ka0 = -1, sd0 = -1, kd0 = -1;
        int exp_ka0, exp_kd0, exp_sd0;
        logic [127:0] vin;
        logic [31:0]  kin;
        vin = 128'h3243f6a8_885a308d_313198a2_e0370734;
        kin = 32'h2b7e1516;
`ifdef SBOX_SHARE_KEY_INTERLEAVE_EN
        exp_ka0 = 1; exp_kd0 = 3; exp_sd0 = 7;
`else
        exp_ka0 = 5; exp_kd0 = 7; exp_sd0 = 5;
`endif
        step();
        st_in = vin; key_in = kin;
        st_req = 1'b1; key_req = 1'b1; st_req_p0 = 1'b1; key_req_p0 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (st_ack === 1'b1 && sa < 0) sa = k;
            if (key_ack === 1'b1 && ka < 0) ka = k;
            if (st_done === 1'b1 && sd < 0) sd = k;
            if (key_done === 1'b1 && kd < 0) kd = k;
            if (st_ack_p0 === 1'b1 && sa0 < 0) sa0 = k;
            if (key_ack_p0 === 1'b1 && ka0 < 0) ka0 = k;
            if (st_done_p0 === 1'b1 && sd0 < 0) sd0 = k;
            if (key_done_p0 === 1'b1 && kd0 < 0) kd0 = k;
            step();
            if (sa >= 0) st_req = 1'b0;
            if (ka >= 0) key_req = 1'b0;
            if (sa0 >= 0) st_req_p0 = 1'b0;
            if (ka0 >= 0) key_req_p0 = 1'b0;
        end
        n_cmp++; if (ka !== 0) begin n_err++; $display("FAIL simul_key_ack: cycle %0d want 0", ka); end
        n_cmp++; if (kd !== 2) begin n_err++; $display("FAIL simul_key_done: cycle %0d want 2", kd); end
        n_cmp++; if (sa !== 2) begin n_err++; $display("FAIL simul_st_ack: cycle %0d want 2", sa); end
        n_cmp++; if (sd !== 7) begin n_err++; $display("FAIL simul_st_done: cycle %0d want 7", sd); end
        n_cmp++; if (sa0 !== 0) begin n_err++; $display("FAIL simul_p0_st_ack: cycle %0d want 0", sa0); end
        n_cmp++; if (ka0 !== exp_ka0) begin n_err++; $display("FAIL simul_p0_key_ack: cycle %0d want %0d", ka0, exp_ka0); end
        n_cmp++; if (sd0 !== exp_sd0) begin n_err++; $display("FAIL simul_p0_st_done: cycle %0d want %0d", sd0, exp_sd0); end
        n_cmp++; if (kd0 !== exp_kd0) begin n_err++; $display("FAIL simul_p0_key_done: cycle %0d want %0d", kd0, exp_kd0); end
        n_cmp++; if ({st_out, key_out} !== {sub_state(vin), sub_word(kin)}) begin n_err++;
            $display("FAIL simul_results: got %h %h want %h %h", st_out, key_out, sub_state(vin), sub_word(kin)); end
        n_cmp++; if ({st_out_p0, key_out_p0} !== {sub_state(vin), sub_word(kin)}) begin n_err++;
            $display("FAIL simul_p0_results: got %h %h want %h %h", st_out_p0, key_out_p0, sub_state(vin), sub_word(kin)); end
        $display("simultaneous: prio1 key@%0d st@%0d done@%0d, prio0 st@%0d key@%0d done@%0d", ka, sa, sd, sa0, ka0, kd0);
    endtask

    task automatic test_key_mid_state();
        int sa = -1, ka = -1, sd = -1, kd = -1;
        int exp_ka, exp_kd;
        logic [127:0] vin;
        logic [31:0]  kin;
        vin = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
        kin = 32'h7ff65a19;
`ifdef SBOX_SHARE_KEY_INTERLEAVE_EN
        exp_ka = 2; exp_kd = 4;
`else
        exp_ka = 5; exp_kd = 7;
`endif
        step();
        st_in = vin; st_req = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) begin key_in = kin; key_req = 1'b1; end
            if (sa >= 0) begin st_req = 1'b0; st_in = '0; end
            if (ka >= 0) begin key_req = 1'b0; key_in = 32'hffffffff; end
            #1;
            if (st_ack === 1'b1 && sa < 0) sa = k;
            if (key_ack === 1'b1 && ka < 0) ka = k;
            if (st_done === 1'b1 && sd < 0) sd = k;
            if (key_done === 1'b1 && kd < 0) kd = k;
            step();
        end
        key_req = 1'b0;
        n_cmp++; if (sa !== 0) begin n_err++; $display("FAIL mid_st_ack: cycle %0d want 0", sa); end
        n_cmp++; if (ka !== exp_ka) begin n_err++; $display("FAIL mid_key_ack: cycle %0d want %0d", ka, exp_ka); end
        n_cmp++; if (kd !== exp_kd) begin n_err++; $display("FAIL mid_key_done: cycle %0d want %0d", kd, exp_kd); end
`ifdef SBOX_SHARE_KEY_INTERLEAVE_EN
        n_cmp++; if (sd !== 7) begin n_err++; $display("FAIL mid_st_done: cycle %0d want 7", sd); end
`else
        n_cmp++; if (sd !== ka) begin n_err++; $display("FAIL mid_st_done_eq_key_ack: st_done %0d key_ack %0d want both 5", sd, ka); end
`endif
        n_cmp++; if (st_out !== sub_state(vin)) begin n_err++; $display("FAIL mid_st_out: got %h want %h", st_out, sub_state(vin)); end
        n_cmp++; if (key_out !== sub_word(kin)) begin n_err++; $display("FAIL mid_key_out: got %h want %h", key_out, sub_word(kin)); end
        $display("key mid-state: key ack@%0d done@%0d, state done@%0d", ka, kd, sd);
    endtask

    task automatic test_reset_mid_job();
        logic [127:0] vin, vin2;
        logic seen;
        vin  = 128'h01020304_05060708_090a0b0c_0d0e0f10;
        vin2 = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;
        step();
        st_in = vin; st_req = 1'b1;
        step(); st_req = 1'b0;
        step();
        step(); #1;
        n_cmp++; if (sb_in !== vin[63:32]) begin n_err++; $display("FAIL rstmid_beat2: got %h want %h", sb_in, vin[63:32]); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if ({st_done, busy, sb_in} !== 34'd0) begin n_err++;
            $display("FAIL rstmid_flags: got done/busy %b sb_in %h want 0", {st_done, busy}, sb_in); end
        n_cmp++; if ({st_out, key_out} !== 160'd0) begin n_err++;
            $display("FAIL rstmid_outs: got %h %h want 0", st_out, key_out); end
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(); #1;
            if (st_done === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done: got done seen %b want 0", seen); end
        st_in = vin2; st_req = 1'b1;
        #1;
        n_cmp++; if (st_ack !== 1'b1) begin n_err++; $display("FAIL rstmid_new_ack: got %b want 1", st_ack); end
        step(); st_req = 1'b0;
        repeat (3) step();
        #1;
        n_cmp++; if (st_done !== 1'b0) begin n_err++; $display("FAIL rstmid_new_early: got %b want 0", st_done); end
        step(); #1;
        n_cmp++; if ({st_done, st_out} !== {1'b1, sub_state(vin2)}) begin n_err++;
            $display("FAIL rstmid_new_done: got done %b out %h want 1 %h", st_done, st_out, sub_state(vin2)); end
        $display("reset mid-job: aborted, new job out=%h", st_out);
    endtask

    task automatic test_back_to_back();
        logic [19:0] kv, sv, exp_kv, exp_sv;
        int last, alt_bad, w;
`ifdef SBOX_SHARE_KEY_INTERLEAVE_EN
        exp_kv = 20'h41209; exp_sv = 20'h00804;
`else
        exp_kv = 20'h04081; exp_sv = 20'h10204;
`endif
        kv = '0; sv = '0;
        step();
        st_in = 128'h00000000_11111111_22222222_33333333; key_in = 32'h44444444;
        st_req = 1'b1; key_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            kv[k] = key_ack;
            sv[k] = st_ack;
            step();
        end
        st_req = 1'b0; key_req = 1'b0;
        n_cmp++; if (kv !== exp_kv) begin n_err++; $display("FAIL b2b_key_acks: got %h want %h", kv, exp_kv); end
        n_cmp++; if (sv !== exp_sv) begin n_err++; $display("FAIL b2b_st_acks: got %h want %h", sv, exp_sv); end
        n_cmp++; if ((kv & sv) !== 20'd0) begin n_err++; $display("FAIL b2b_double_ack: got %h want 0", kv & sv); end
`ifndef SBOX_SHARE_KEY_INTERLEAVE_EN
        last = -1; alt_bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (kv[k] === 1'b1) begin if (last == 1) alt_bad++; last = 1; end
            if (sv[k] === 1'b1) begin if (last == 0) alt_bad++; last = 0; end
        end
        n_cmp++; if (alt_bad !== 0) begin n_err++; $display("FAIL b2b_alternate: got %0d repeats want 0", alt_bad); end
`endif
        w = 0;
        while (busy !== 1'b0 && w < 20) begin
            step();
            w++;
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_drain: busy still %b after %0d cycles", busy, w); end
        $display("back-to-back: key acks %h, state acks %h, drained in %0d", kv, sv, w);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        sbox_flat = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) sbox[i] = sbox_flat[i*8 +: 8];

        test_reset();
        test_state_job();
        test_key_only();
        test_simultaneous();
        test_key_mid_state();
        test_reset_mid_job();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
